// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: two-requester VRAM write arbiter (capture, overlay) with
// a starvation guard for the overlay port, out-of-range drop counter, and
// frame-sync driven bank toggle.
// Optional frame clear engine enabled by defining VRAM_WRITE_ARBITER_CLEAR_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | arbitrate capture/overlay requests, frame sync toggles bank
// ST_CLEAR | fill addresses 0..DEPTH-1 with the latched clear colour
module vram_write_arbiter #(
  parameter int ADDR_WIDTH   = 15,
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 23040,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstN,
  input  logic                  i_capValid,
  input  logic [ADDR_WIDTH-1:0] i_capAddr,
  input  logic [DATA_WIDTH-1:0] i_capData,
  output logic                  o_capReady,
  input  logic                  i_ovlValid,
  input  logic [ADDR_WIDTH-1:0] i_ovlAddr,
  input  logic [DATA_WIDTH-1:0] i_ovlData,
  output logic                  o_ovlReady,
  input  logic                  i_clearStart,
  input  logic [DATA_WIDTH-1:0] i_clearColor,
  input  logic                  i_frameSync,
  output logic                  o_vramWriteEnable,
  output logic [ADDR_WIDTH-1:0] o_vramWriteAddr,
  output logic [DATA_WIDTH-1:0] o_vramDataOut,
  output logic                  o_clearBusy,
  output logic                  o_writeBank,
  output logic [7:0]            o_dropCount
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]       LP_STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH:0] LP_DEPTH      = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  w_idle;
  logic                  w_starved;
  logic                  w_cap_grant;
  logic                  w_ovl_grant;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_oob;

  logic [SW-1:0]         r_starve;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [7:0]            r_drop;
  logic                  r_bank;

`ifdef VRAM_WRITE_ARBITER_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic [DATA_WIDTH-1:0] r_clr_color;
  logic                  r_pend;

  // state register
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // next state: start a clear from idle, leave after the last address
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_clearStart) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (r_clr_addr == LP_LAST) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // clear address walker and colour latched at start
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_clr_addr  <= '0;
      r_clr_color <= '0;
    end else if (r_state == ST_IDLE) begin
      if (i_clearStart) begin
        r_clr_addr  <= '0;
        r_clr_color <= i_clearColor;
      end
    end else begin
      r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  // bank toggle; syncs arriving during a clear collapse into one deferred toggle
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_bank <= 1'b0;
      r_pend <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      if (i_frameSync) r_pend <= 1'b1;
    end else if (i_frameSync || r_pend) begin
      r_bank <= ~r_bank;
      r_pend <= 1'b0;
    end
  end

  assign w_idle      = (r_state == ST_IDLE);
  assign o_clearBusy = (r_state == ST_CLEAR);
`else
  logic w_unused_clear;
  assign w_unused_clear = ^{i_clearStart, i_clearColor};

  // bank toggles on every frame sync
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN)          r_bank <= 1'b0;
    else if (i_frameSync) r_bank <= ~r_bank;
  end

  assign w_idle      = 1'b1;
  assign o_clearBusy = 1'b0;
`endif

  // capture has priority unless the overlay has waited STARVE_LIMIT cycles;
  // readies are gated by reset so nothing is accepted while held in reset
  assign w_starved   = (r_starve == LP_STARVE_MAX);
  assign w_ovl_grant = i_rstN & w_idle & i_ovlValid & (~i_capValid | w_starved);
  assign w_cap_grant = i_rstN & w_idle & i_capValid & ~w_ovl_grant;
  assign w_xfer      = w_cap_grant | w_ovl_grant;
  assign w_addr      = w_ovl_grant ? i_ovlAddr : i_capAddr;
  assign w_data      = w_ovl_grant ? i_ovlData : i_capData;
  assign w_oob       = ({1'b0, w_addr} >= LP_DEPTH);

  // overlay starvation counter
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN)                         r_starve <= '0;
    else if (w_ovl_grant || !i_ovlValid) r_starve <= '0;
    else if (!w_starved)                 r_starve <= r_starve + 1'b1;
  end

  // registered VRAM write port: clear writes or accepted in-range requests
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
`ifdef VRAM_WRITE_ARBITER_CLEAR_EN
    end else if (!w_idle) begin
      r_we   <= 1'b1;
      r_addr <= r_clr_addr;
      r_data <= r_clr_color;
`endif
    end else if (w_xfer) begin
      r_we   <= ~w_oob;
      r_addr <= w_addr;
      r_data <= w_data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  // saturating count of accepted out-of-range writes
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN)                                 r_drop <= '0;
    else if (w_xfer && w_oob && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
  end

  assign o_capReady        = w_cap_grant;
  assign o_ovlReady        = w_ovl_grant;
  assign o_vramWriteEnable = r_we;
  assign o_vramWriteAddr   = r_addr;
  assign o_vramDataOut     = r_data;
  assign o_writeBank       = r_bank;
  assign o_dropCount       = r_drop;

endmodule
